// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised Moore serial pattern detector.
// Tracks the longest matched pattern prefix, raises o_y while the full pattern
// is matched and tallies matches in a saturating counter.
// Optional feature: define PAT_LOAD_EN to make the pattern runtime-loadable
// through i_pat_ld / i_pat_in; otherwise the constant PATTERN is used.
module seq_detect_param #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_a,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_pat_ld,
    input  logic [PAT_W-1:0] i_pat_in,
    output logic             o_y,
    output logic [CNT_W-1:0] o_match_cnt
);

    localparam int          P    = int'(PAT_W);
    localparam int unsigned ST_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] w_pat;
    logic             w_load;
    logic [ST_W-1:0]  w_st_nxt;
    logic             w_hit;

    logic [ST_W-1:0]  r_st;
    logic             r_y;
    logic [CNT_W-1:0] r_cnt;

`ifdef PAT_LOAD_EN
    logic [PAT_W-1:0] r_pat;

    // Active pattern register, reloaded on i_pat_ld
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pat <= PATTERN;
        end else if (i_pat_ld) begin
            r_pat <= i_pat_in;
        end
    end

    assign w_pat  = r_pat;
    assign w_load = i_pat_ld;
`else
    logic w_unused_pat;

    assign w_pat        = PATTERN;
    assign w_load       = 1'b0;
    assign w_unused_pat = ^{i_pat_ld, i_pat_in};
`endif

    // Next state: longest pattern prefix that is a suffix of (matched prefix, i_a).
    // Bit index f counted first-received-first maps to w_pat[PAT_W-1-f].
    always_comb begin
        int   k;
        int   best;
        int   idx;
        logic ok;
        k    = int'(r_st);
        best = 0;
        idx  = 0;
        ok   = 1'b0;
        // Without overlap a completed match restarts from an empty history
        if (k == P && !OVERLAP) begin
            k = 0;
        end
        if (k <= P) begin
            for (int j = 1; j <= P; j++) begin
                // Candidate length j: last bit must be i_a, earlier j-1 bits come
                // from the tail of the matched prefix
                ok = (j <= k + 1) && (i_a == w_pat[P-j]);
                for (int m = 0; m < P - 1; m++) begin
                    if (m < j - 1) begin
                        idx = k + 1 - j + m;
                        if (idx >= 0 && idx < P) begin
                            ok = ok && (w_pat[P-1-idx] == w_pat[P-1-m]);
                        end else begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        // Encodings above PAT_W fall through with best = 0
        w_st_nxt = ST_W'(best);
    end

    assign w_hit = (w_st_nxt == ST_W'(PAT_W));

    // Prefix-length state and registered Moore flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_st <= '0;
            r_y  <= 1'b0;
        end else if (w_load) begin
            r_st <= '0;
            r_y  <= 1'b0;
        end else if (i_en) begin
            r_st <= w_st_nxt;
            r_y  <= w_hit;
        end
    end

    // Saturating match counter; clear wins over increment
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_load && w_hit && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_y         = r_y;
    assign o_match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three instances (overlap, non-overlap, 2-bit counter)
// checked against a bit-history model, a vector table and hand-written corner cases.
module tb_seq_detect_param;

    localparam int PW = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       a     = 1'b0;
    logic       en    = 1'b0;
    logic       clr   = 1'b0;
    logic       ld    = 1'b0;
    logic [3:0] pin   = 4'b0000;

    logic       y0, y1, y2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    int total = 0;
    int bad   = 0;

    // Reference model: raw received-bit history per instance
    logic [3:0]  mpat;
    logic [31:0] mh   [3];
    int          mlen [3];
    int          mcnt [3];
    int          my   [3];
    bit          mov  [3] = '{1'b1, 1'b0, 1'b1};
    int          mmax [3] = '{255, 255, 3};

    typedef struct {
        logic a;
        logic en;
        logic clr;
        logic ey;
        int   ecnt;
    } vec_t;

    vec_t tbl [21];

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_en(en), .i_clr(clr),
        .i_pat_ld(ld), .i_pat_in(pin), .o_y(y0), .o_match_cnt(c0)
    );

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_en(en), .i_clr(clr),
        .i_pat_ld(ld), .i_pat_in(pin), .o_y(y1), .o_match_cnt(c1)
    );

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_en(en), .i_clr(clr),
        .i_pat_ld(ld), .i_pat_in(pin), .o_y(y2), .o_match_cnt(c2)
    );

    task automatic cmp(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            mh[d]   = '0;
            mlen[d] = 0;
            mcnt[d] = 0;
            my[d]   = 0;
        end
        mpat = 4'b1010;
    endtask

    task automatic model_step();
        bit ld_eff;
        bit hit;
`ifdef PAT_LOAD_EN
        ld_eff = ld;
`else
        ld_eff = 1'b0;
`endif
        for (int d = 0; d < 3; d++) begin
            if (ld_eff) begin
                mlen[d] = 0;
                my[d]   = 0;
            end else if (en) begin
                mh[d] = {mh[d][30:0], a};
                if (mlen[d] < 32) mlen[d]++;
                hit   = (mlen[d] >= PW) && (mh[d][3:0] == mpat);
                my[d] = hit ? 1 : 0;
                if (hit) begin
                    if (mcnt[d] < mmax[d]) mcnt[d]++;
                    if (!mov[d]) mlen[d] = 0;
                end
            end
            if (clr) mcnt[d] = 0;
        end
        if (ld_eff) mpat = pin;
    endtask

    task automatic check_all(input string tag);
        cmp($sformatf("%s_y0", tag), int'(y0), my[0]);
        cmp($sformatf("%s_c0", tag), int'(c0), mcnt[0]);
        cmp($sformatf("%s_y1", tag), int'(y1), my[1]);
        cmp($sformatf("%s_c1", tag), int'(c1), mcnt[1]);
        cmp($sformatf("%s_y2", tag), int'(y2), my[2]);
        cmp($sformatf("%s_c2", tag), int'(c2), mcnt[2]);
    endtask

    task automatic step(input logic ia, input logic ien, input logic iclr,
                        input logic ild, input logic [3:0] ipin, input string tag);
        a   = ia;
        en  = ien;
        clr = iclr;
        ld  = ild;
        pin = ipin;
        @(posedge clk);
        #1;
        model_step();
        check_all(tag);
    endtask

    // Asynchronous reset pulse asserted between edges
    task automatic do_reset();
        en  = 1'b0;
        clr = 1'b0;
        ld  = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        cmp("rst_y0_now", int'(y0), 0);
        cmp("rst_c0_now", int'(c0), 0);
        check_all("rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] s10;
        logic [3:0] s11010;
        int         exp_cnt2 [5] = '{1, 2, 3, 3, 3};

        model_clear();
        #3;
        cmp("por_y0", int'(y0), 0);
        cmp("por_c0", int'(c0), 0);
        check_all("por");
        #9;
        rst_n = 1'b1;

        // a, en, clr -> expected y0, c0 after the edge
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 0};

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].a, tbl[i].en, tbl[i].clr, 1'b0, 4'b0000, $sformatf("tbl%0d", i));
            cmp($sformatf("tbl%0d_y", i), int'(y0), int'(tbl[i].ey));
            cmp($sformatf("tbl%0d_cnt", i), int'(c0), tbl[i].ecnt);
        end

        // Repeated leading 1 must not lose the match
        do_reset();
        s11010 = 4'b1010;
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, "rep0");
        for (int i = 3; i >= 0; i--) begin
            step(s11010[i], 1'b1, 1'b0, 1'b0, 4'b0000, "rep");
        end
        cmp("rep_y0", int'(y0), 1);
        cmp("rep_c0", int'(c0), 1);

        // Overlap vs non-overlap on 101010
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step((i % 2) == 0, 1'b1, 1'b0, 1'b0, 4'b0000, "ovl");
            if (i == 3) cmp("ovl_b4_y1", int'(y1), 1);
        end
        cmp("ovl_y0", int'(y0), 1);
        cmp("ovl_c0", int'(c0), 2);
        cmp("novl_y1", int'(y1), 0);
        cmp("novl_c1", int'(c1), 1);

        // 2-bit counter saturation, then clear coincident with a match
        do_reset();
        s10 = 4'b1010;
        for (int i = 3; i >= 2; i--) step(s10[i], 1'b1, 1'b0, 1'b0, 4'b0000, "sat");
        for (int m = 0; m < 5; m++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, "sat");
            step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, "sat");
            cmp($sformatf("sat%0d_c2", m), int'(c2), exp_cnt2[m]);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, "clrm");
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, "clrm");
        cmp("clrm_y2", int'(y2), 1);
        cmp("clrm_c2", int'(c2), 0);

        // Reset mid-sequence discards the partial match
        do_reset();
        for (int i = 3; i >= 1; i--) step(s10[i], 1'b1, 1'b0, 1'b0, 4'b0000, "mid");
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, "mid");
        cmp("mid_y0", int'(y0), 0);
        cmp("mid_c0", int'(c0), 0);

        // pat_ld on the completing bit: loaded build drops the bit, fixed build ignores pat_ld
        do_reset();
        for (int i = 3; i >= 1; i--) step(s10[i], 1'b1, 1'b0, 1'b0, 4'b0000, "ldp");
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'b1010, "ldp");
`ifdef PAT_LOAD_EN
        cmp("ldp_y0", int'(y0), 0);
`else
        cmp("ldp_y0", int'(y0), 1);
`endif

`ifdef PAT_LOAD_EN
        // Runtime pattern 1100
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, "pld");
        s10 = 4'b1100;
        for (int i = 3; i >= 0; i--) step(s10[i], 1'b1, 1'b0, 1'b0, 4'b0000, "pld");
        cmp("pld_hit_y0", int'(y0), 1);
        s10 = 4'b1010;
        for (int i = 3; i >= 0; i--) begin
            step(s10[i], 1'b1, 1'b0, 1'b0, 4'b0000, "pld2");
            cmp("pld_old_y0", int'(y0), 0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, "pldr");
`endif

        // Randomised run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) do_reset();
            step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
                 4'($urandom_range(0, 15)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
